// File: rtl/pb_keypad_encoder.sv
// Pushbutton conditioner: two-flop synchroniser, per-bit debounce, clean edge
// pulses, and a priority encoder that strobes the highest newly pressed key.
module pb_keypad_encoder #(
    parameter int WIDTH    = 20,
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 3
) (
    input  logic             hz100,
    input  logic             reset,
    input  logic [WIDTH-1:0] pb_raw,
    output logic [WIDTH-1:0] pb_clean,
    output logic [WIDTH-1:0] pb_rise,
    output logic [WIDTH-1:0] pb_fall,
    output logic             key_strobe,
    output logic [4:0]       key_code,
    output logic             key_multi,
    output logic             any_pressed
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];
    logic [WIDTH-1:0] accept;

    logic [4:0]       rise_idx;
    logic             rise_any;
    logic             rise_multi;

    // A bit is accepted on the edge where it has disagreed with pb_clean for
    // DEBOUNCE consecutive samples; any agreement in between restarts the count.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (s2[i] != pb_clean[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    accept[i] = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Ascending scan so the last hit (highest index) wins the code.
    always_comb begin
        rise_idx   = '0;
        rise_any   = 1'b0;
        rise_multi = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pb_rise[i]) begin
                if (rise_any) begin
                    rise_multi = 1'b1;
                end
                rise_any = 1'b1;
                rise_idx = 5'(i);
            end
        end
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            s1       <= '0;
            s2       <= '0;
            pb_clean <= '0;
            pb_rise  <= '0;
            pb_fall  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1       <= pb_raw;
            s2       <= s1;
            pb_clean <= pb_clean ^ accept;
            pb_rise  <= accept & s2;
            pb_fall  <= accept & ~s2;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    // key_code and key_multi keep the last press until the next one arrives.
    always_ff @(posedge hz100) begin
        if (reset) begin
            key_strobe <= 1'b0;
            key_code   <= '0;
            key_multi  <= 1'b0;
        end else begin
            key_strobe <= rise_any;
            if (rise_any) begin
                key_code  <= rise_idx;
                key_multi <= rise_multi;
            end
        end
    end

    assign any_pressed = |pb_clean;

endmodule

// File: tb/tb_pb_keypad_encoder.sv
// Directed bench for pb_keypad_encoder: each task drives one scenario and
// compares outputs against hand-computed cycle-by-cycle expectations.
module tb_pb_keypad_encoder;

    logic        hz100;
    logic        reset;
    logic [19:0] pb_raw;
    logic [19:0] pb_clean;
    logic [19:0] pb_rise;
    logic [19:0] pb_fall;
    logic        key_strobe;
    logic [4:0]  key_code;
    logic        key_multi;
    logic        any_pressed;

    int checks   = 0;
    int failures = 0;

    pb_keypad_encoder #(
        .WIDTH   (20),
        .DEBOUNCE(4),
        .CNT_W   (3)
    ) dut (
        .hz100      (hz100),
        .reset      (reset),
        .pb_raw     (pb_raw),
        .pb_clean   (pb_clean),
        .pb_rise    (pb_rise),
        .pb_fall    (pb_fall),
        .key_strobe (key_strobe),
        .key_code   (key_code),
        .key_multi  (key_multi),
        .any_pressed(any_pressed)
    );

    // clock / reset
    initial hz100 = 1'b0;
    always #5 hz100 = ~hz100;

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1);
    end

    // Tick k=1 is the edge that samples a new pb_raw into s1.
    task automatic tick();
        @(posedge hz100);
        #1;
    endtask

    task automatic settle();
        pb_raw = '0;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        logic [19:0] exp_clean, exp_rise;
        logic        exp_strobe;
        reset  = 1'b1;
        pb_raw = 20'hFFFFF;
        for (int k = 0; k < 3; k++) begin
            tick();
            if ({pb_clean, pb_rise, pb_fall, key_strobe, key_code, key_multi, any_pressed} !== 68'd0) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d clean=%h rise=%h fall=%h strobe=%b code=%0d multi=%b any=%b required all 0",
                         k, pb_clean, pb_rise, pb_fall, key_strobe, key_code, key_multi, any_pressed);
            end
            checks++;
        end
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_clean  = (k >= 6) ? 20'hFFFFF : 20'h0;
            exp_rise   = (k == 6) ? 20'hFFFFF : 20'h0;
            exp_strobe = (k == 7);
            if (pb_clean !== exp_clean) begin
                failures++;
                $display("FAIL held_reset_clean k=%0d got=%h exp=%h", k, pb_clean, exp_clean);
            end
            checks++;
            if (pb_rise !== exp_rise) begin
                failures++;
                $display("FAIL held_reset_rise k=%0d got=%h exp=%h", k, pb_rise, exp_rise);
            end
            checks++;
            if (key_strobe !== exp_strobe) begin
                failures++;
                $display("FAIL held_reset_strobe k=%0d got=%b exp=%b", k, key_strobe, exp_strobe);
            end
            checks++;
            if (k == 7) begin
                if (key_code !== 5'd19 || key_multi !== 1'b1) begin
                    failures++;
                    $display("FAIL held_reset_code got code=%0d multi=%b exp code=19 multi=1", key_code, key_multi);
                end
                checks++;
                if (any_pressed !== 1'b1) begin
                    failures++;
                    $display("FAIL held_reset_any got=%b exp=1", any_pressed);
                end
                checks++;
            end
        end
        settle();
        if (pb_clean !== 20'h0 || any_pressed !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_all got clean=%h any=%b exp 0", pb_clean, any_pressed);
        end
        checks++;
    endtask

    task automatic test_clean_press();
        logic [19:0] exp_clean, exp_rise;
        pb_raw = 20'h00020;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_clean = (k >= 6) ? 20'h00020 : 20'h0;
            exp_rise  = (k == 6) ? 20'h00020 : 20'h0;
            if (pb_clean !== exp_clean || pb_rise !== exp_rise) begin
                failures++;
                $display("FAIL press_clean_rise k=%0d got clean=%h rise=%h exp clean=%h rise=%h",
                         k, pb_clean, pb_rise, exp_clean, exp_rise);
            end
            checks++;
            if (key_strobe !== (k == 7)) begin
                failures++;
                $display("FAIL press_strobe k=%0d got=%b exp=%b", k, key_strobe, (k == 7));
            end
            checks++;
            if (k == 7 && (key_code !== 5'd5 || key_multi !== 1'b0)) begin
                failures++;
                $display("FAIL press_code got code=%0d multi=%b exp code=5 multi=0", key_code, key_multi);
            end
            if (k == 7) checks++;
        end
        settle();
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 14; k++) begin
            pb_raw    = '0;
            pb_raw[3] = (k < 4) ? ~k[0] : 1'b0;
            tick();
            if (pb_clean[3] !== 1'b0 || pb_rise !== 20'h0 || key_strobe !== 1'b0) begin
                failures++;
                $display("FAIL bounce k=%0d got clean3=%b rise=%h strobe=%b exp 0", k, pb_clean[3], pb_rise, key_strobe);
            end
            checks++;
        end
        settle();
    endtask

    task automatic test_glitch_boundary();
        logic [19:0] exp_clean, exp_fall;
        // DEBOUNCE-1 samples high: rejected.
        for (int k = 1; k <= 12; k++) begin
            pb_raw = (k <= 3) ? 20'h00080 : 20'h0;
            tick();
            if (pb_clean !== 20'h0 || pb_rise !== 20'h0 || key_strobe !== 1'b0) begin
                failures++;
                $display("FAIL glitch3 k=%0d got clean=%h rise=%h strobe=%b exp 0", k, pb_clean, pb_rise, key_strobe);
            end
            checks++;
        end
        // Exactly DEBOUNCE samples high: accepted, then released.
        for (int k = 1; k <= 12; k++) begin
            pb_raw = (k <= 4) ? 20'h00080 : 20'h0;
            tick();
            exp_clean = (k >= 6 && k <= 9) ? 20'h00080 : 20'h0;
            exp_fall  = (k == 10) ? 20'h00080 : 20'h0;
            if (pb_clean !== exp_clean || pb_fall !== exp_fall) begin
                failures++;
                $display("FAIL glitch4 k=%0d got clean=%h fall=%h exp clean=%h fall=%h",
                         k, pb_clean, pb_fall, exp_clean, exp_fall);
            end
            checks++;
            if (k == 7 && (key_strobe !== 1'b1 || key_code !== 5'd7)) begin
                failures++;
                $display("FAIL glitch4_strobe got strobe=%b code=%0d exp strobe=1 code=7", key_strobe, key_code);
            end
            if (k == 7) checks++;
        end
        settle();
    endtask

    task automatic test_release();
        logic [19:0] exp_clean, exp_fall;
        pb_raw = 20'h01000;
        repeat (20) tick();
        if (pb_clean !== 20'h01000 || key_code !== 5'd12) begin
            failures++;
            $display("FAIL release_hold got clean=%h code=%0d exp clean=01000 code=12", pb_clean, key_code);
        end
        checks++;
        pb_raw = 20'h0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_clean = (k < 6) ? 20'h01000 : 20'h0;
            exp_fall  = (k == 6) ? 20'h01000 : 20'h0;
            if (pb_clean !== exp_clean || pb_fall !== exp_fall) begin
                failures++;
                $display("FAIL release k=%0d got clean=%h fall=%h exp clean=%h fall=%h",
                         k, pb_clean, pb_fall, exp_clean, exp_fall);
            end
            checks++;
            if (key_strobe !== 1'b0 || key_code !== 5'd12) begin
                failures++;
                $display("FAIL release_strobe k=%0d got strobe=%b code=%0d exp strobe=0 code=12", k, key_strobe, key_code);
            end
            checks++;
        end
        settle();
    endtask

    task automatic test_simultaneous();
        int strobes = 0;
        pb_raw = 20'h00204;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (key_strobe === 1'b1) strobes++;
            if (k == 6 && pb_rise !== 20'h00204) begin
                failures++;
                $display("FAIL simul_rise got=%h exp=00204", pb_rise);
            end
            if (k == 6) checks++;
            if (k == 7 && (key_strobe !== 1'b1 || key_code !== 5'd9 || key_multi !== 1'b1)) begin
                failures++;
                $display("FAIL simul_code got strobe=%b code=%0d multi=%b exp strobe=1 code=9 multi=1",
                         key_strobe, key_code, key_multi);
            end
            if (k == 7) checks++;
        end
        if (strobes != 1) begin
            failures++;
            $display("FAIL simul_strobe_count got=%0d exp=1", strobes);
        end
        checks++;
        settle();
    endtask

    task automatic test_same_edge();
        int strobes = 0;
        pb_raw = 20'h01000;
        repeat (10) tick();
        pb_raw = 20'h00010;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (key_strobe === 1'b1) strobes++;
            if (k == 6 && (pb_rise !== 20'h00010 || pb_fall !== 20'h01000 || pb_clean !== 20'h00010)) begin
                failures++;
                $display("FAIL same_edge_pulses got rise=%h fall=%h clean=%h exp rise=00010 fall=01000 clean=00010",
                         pb_rise, pb_fall, pb_clean);
            end
            if (k == 6) checks++;
            if (k == 7 && (key_strobe !== 1'b1 || key_code !== 5'd4 || key_multi !== 1'b0)) begin
                failures++;
                $display("FAIL same_edge_code got strobe=%b code=%0d multi=%b exp strobe=1 code=4 multi=0",
                         key_strobe, key_code, key_multi);
            end
            if (k == 7) checks++;
        end
        if (strobes != 1) begin
            failures++;
            $display("FAIL same_edge_strobe_count got=%0d exp=1", strobes);
        end
        checks++;
        settle();
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp_rise;
        pb_raw = 20'h08000;
        tick();
        pb_raw = 20'h28000;
        for (int k = 2; k <= 9; k++) begin
            tick();
            exp_rise = (k == 6) ? 20'h08000 : ((k == 7) ? 20'h20000 : 20'h0);
            if (pb_rise !== exp_rise) begin
                failures++;
                $display("FAIL b2b_rise k=%0d got=%h exp=%h", k, pb_rise, exp_rise);
            end
            checks++;
            if (key_strobe !== (k == 7 || k == 8)) begin
                failures++;
                $display("FAIL b2b_strobe k=%0d got=%b exp=%b", k, key_strobe, (k == 7 || k == 8));
            end
            checks++;
            if ((k == 7 && key_code !== 5'd15) || (k == 8 && key_code !== 5'd17)) begin
                failures++;
                $display("FAIL b2b_code k=%0d got=%0d exp=%0d", k, key_code, (k == 7) ? 15 : 17);
            end
            if (k == 7 || k == 8) checks++;
        end
        settle();
    endtask

    task automatic test_mid_debounce_reset();
        logic [19:0] exp_clean;
        pb_raw = 20'h00001;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        if (pb_clean !== 20'h0 || key_code !== 5'd0 || key_strobe !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got clean=%h code=%0d strobe=%b exp all 0", pb_clean, key_code, key_strobe);
        end
        checks++;
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_clean = (k >= 6) ? 20'h00001 : 20'h0;
            if (pb_clean !== exp_clean || pb_rise !== ((k == 6) ? 20'h00001 : 20'h0)) begin
                failures++;
                $display("FAIL mid_reset_redebounce k=%0d got clean=%h rise=%h exp clean=%h", k, pb_clean, pb_rise, exp_clean);
            end
            checks++;
            if (key_strobe !== (k == 7)) begin
                failures++;
                $display("FAIL mid_reset_strobe k=%0d got=%b exp=%b", k, key_strobe, (k == 7));
            end
            checks++;
        end
        settle();
    endtask

    initial begin
        reset  = 1'b1;
        pb_raw = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch_boundary();
        test_release();
        test_simultaneous();
        test_same_edge();
        test_back_to_back();
        test_mid_debounce_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
